// File: rtl/pc_redirect_unit.sv
// Program-counter owner: issues sequential fetch addresses under a valid/ready handshake
// and applies EX-stage redirects (branch/JAL target or JALR result), flushing the wrong path.
module pc_redirect_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [1:0]      bc_sel,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] alu_out,
    input  logic            stall,
    input  logic            if_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            if_valid,
    output logic            flush,
    output logic            misaligned_err,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    // Handshake: a fetch is taken on an edge where if_valid & if_ready are both high
    // and stall is low; while not taken, pc and if_valid hold steady.

    localparam logic [XLEN-1:0] PC_STEP      = XLEN'(4);
    localparam logic [XLEN-1:0] JALR_MASK    = ~XLEN'(1);
    localparam logic [2:0]      FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t          r_state;
    logic [2:0]      r_flush_cnt;
    logic [XLEN-1:0] r_pc;
    logic            r_if_valid;
    logic            r_flush;
    logic            r_misaligned;

    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_target_misaligned;
    logic            w_advance;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_taken             = redirect_valid & ((bc_sel == 2'b01) | (bc_sel == 2'b10));
    assign w_target            = (bc_sel == 2'b10) ? (alu_out & JALR_MASK) : branch_target;
    assign w_target_misaligned = |w_target[1:0];
    assign w_advance           = r_if_valid & if_ready & ~stall;
    assign w_pc_plus4          = r_pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_flush_cnt  <= 3'd0;
            r_pc         <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (r_state != ST_TRAP) begin
            if (w_taken) begin
                if (w_target_misaligned) begin
                    // pc stays on the last good address so the trap handler can inspect it
                    r_state      <= ST_TRAP;
                    r_flush_cnt  <= 3'd0;
                    r_if_valid   <= 1'b0;
                    r_flush      <= 1'b0;
                    r_misaligned <= 1'b1;
                end else begin
                    r_state     <= ST_FLUSH;
                    r_flush_cnt <= FLUSH_RELOAD;
                    r_pc        <= w_target;
                    r_if_valid  <= 1'b0;
                    r_flush     <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_BOOT: begin
                        r_state    <= ST_RUN;
                        r_if_valid <= 1'b1;
                    end
                    ST_RUN: begin
                        if (w_advance) begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_flush_cnt == 3'd0) begin
                            r_state    <= ST_RUN;
                            r_if_valid <= 1'b1;
                            r_flush    <= 1'b0;
                        end else begin
                            r_flush_cnt <= r_flush_cnt - 3'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;
    assign if_valid       = r_if_valid;
    assign flush          = r_flush;
    assign misaligned_err = r_misaligned;
    assign dbg_state      = r_state;

endmodule
